// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// the legal byte-enable patterns and the legality check used at commit time.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } datamem_state_type;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  localparam int DATAMEM_WAIT_STATES_DEFAULT = 2;

  // Only naturally aligned byte, half and word lanes are accepted; 0000 is an error.
  function automatic logic be_is_legal(input logic [3:0] be);
    case (be)
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
      BE_HALF0, BE_HALF1, BE_WORD: be_is_legal = 1'b1;
      default:                     be_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/datamem_byte_ram.sv
// Word-organised storage with one write enable per byte lane and an
// asynchronous read of the addressed word. Contents are not affected by reset.
module datamem_byte_ram #(
  parameter int WORD_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic [3:0]                 we_i,
  input  logic [WORD_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o
);

  logic [31:0] mem_q [2**WORD_ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we_i[lane]) begin
        mem_q[addr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: valid/ready request, WAIT_STATES wait cycles,
// byte-lane commit on entry to RESP. Optional DATAMEM_ACCESS_STATS_EN adds load/store counters.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = DATAMEM_WAIT_STATES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_byte_enable,
  input  logic [31:0]           req_write_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_read_data,
  output logic                  resp_error,
  output logic [1:0]            dbg_state
`ifdef DATAMEM_ACCESS_STATS_EN
  ,
  output logic [31:0]           load_count,
  output logic [31:0]           store_count
`endif
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready.

  localparam int WAW = ADDR_WIDTH - 2;
  localparam int CW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  datamem_state_type state_q;
  logic [CW-1:0]     cnt_q;
  logic              wr_q;
  logic [WAW-1:0]    addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              use_in;
  logic              cur_wr;
  logic [WAW-1:0]    cur_addr;
  logic [3:0]        cur_be;
  logic [31:0]       cur_wdata;
  logic              cur_legal;
  logic              commit;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;
  logic              addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr[1:0];
  assign accept          = req_valid && req_ready_q;

  // With zero wait states the commit edge is the accept edge, so the live
  // request fields drive the RAM instead of the capture registers.
  assign use_in    = (state_q == IDLE);
  assign cur_wr    = use_in ? req_write                  : wr_q;
  assign cur_addr  = use_in ? req_addr[ADDR_WIDTH-1:2]   : addr_q;
  assign cur_be    = use_in ? req_byte_enable            : be_q;
  assign cur_wdata = use_in ? req_write_data             : wdata_q;
  assign cur_legal = be_is_legal(cur_be);

  assign commit = !reset && (((state_q == WAIT) && (cnt_q == '0)) ||
                             ((WAIT_STATES == 0) && accept));
  assign ram_we = (commit && cur_wr && cur_legal) ? cur_be : 4'b0000;

  datamem_byte_ram #(
    .WORD_ADDR_WIDTH(WAW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (cur_addr),
    .wdata_i(cur_wdata),
    .rdata_o(ram_rdata)
  );

`ifdef DATAMEM_ACCESS_STATS_EN
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
`ifdef DATAMEM_ACCESS_STATS_EN
      load_cnt_q   <= 32'h0;
      store_cnt_q  <= 32'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wr_q        <= req_write;
            addr_q      <= req_addr[ADDR_WIDTH-1:2];
            be_q        <= req_byte_enable;
            wdata_q     <= req_write_data;
            req_ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (commit) begin
        rdata_q <= (cur_legal && !cur_wr) ? ram_rdata : 32'h0;
        err_q   <= !cur_legal;
`ifdef DATAMEM_ACCESS_STATS_EN
        if (cur_legal && cur_wr)  store_cnt_q <= store_cnt_q + 32'd1;
        if (cur_legal && !cur_wr) load_cnt_q  <= load_cnt_q + 32'd1;
`endif
      end
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_read_data = rdata_q;
  assign resp_error     = err_q;
  assign dbg_state      = state_q;

`ifdef DATAMEM_ACCESS_STATS_EN
  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`endif

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Memory-side responder for the CPU data-memory port. It accepts byte-enabled load/store requests over a valid/ready handshake, models a configurable number of wait states, commits writes per byte lane, and returns a word-aligned read word plus an error flag. The CPU-side load/store interface (lane shifting, sign extension) sits in front of it; this block replaces the single-cycle data memory whenever multi-cycle memory timing is exercised.

Parameters:
ADDR_WIDTH, 10, byte-address width; storage depth = 2^(ADDR_WIDTH-2) 32-bit words
WAIT_STATES, 2, cycles spent in WAIT between accept and response; 0 is legal

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored for indexing
req_byte_enable  in  4  lanes to write (store) or check (load)
req_write_data  in  32  lane-aligned store data
resp_valid  out  1  response present
resp_ready  in  1  CPU consumes response
resp_read_data  out  32  full word at the word address (loads); 0 for stores and errors
resp_error  out  1  illegal byte-enable pattern

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
- FSM states IDLE, WAIT, RESP. Reset -> IDLE, req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0, wait counter=0.
- IDLE: req_ready=1. On req_valid && req_ready, capture write, word address, byte enable and write data. Next state is WAIT with counter=WAIT_STATES-1, or RESP if WAIT_STATES=0.
- WAIT: req_ready=0. Counter decrements each cycle. At counter==0, next state is RESP.
- Commit happens on the edge entering RESP:
  - Legal byte enables are 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other pattern, including 0000, is an error.
  - Legal store: write only the enabled lanes; disabled lanes are unchanged.
  - Legal load: resp_read_data = stored word, unmasked and unshifted.
  - Error: no write; resp_read_data=0, resp_error=1.
- RESP: resp_valid=1, and data/error stay stable until resp_ready. On resp_valid && resp_ready, return to IDLE and clear resp_read_data and resp_error. Back-to-back requests need one IDLE cycle, so at most one request is outstanding.
- Latency: accept at edge T gives resp_valid high from T+1+WAIT_STATES.
- Inputs are ignored while req_ready=0. req_* may change freely after the accept edge.
- Read-after-write: a load that follows a store to the same word returns the updated lanes.
- Reset mid-operation: reset in WAIT aborts the request with no write. Reset in RESP drops the response, but a store already committed stays committed. Storage contents are never cleared by reset.
- Address wrap: none. All 2^ADDR_WIDTH byte addresses map in range.

Optional Feature:
DATAMEM_ACCESS_STATS_EN
- Defined: adds outputs load_count[31:0] and store_count[31:0], both reset to 0. Each increments by 1 on the edge entering RESP for a legal, non-error load or store. Wraps modulo 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package common:
  - datamem_state_type enum {IDLE, WAIT, RESP}
  - constants for the seven legal byte-enable patterns
  - DATAMEM_WAIT_STATES_DEFAULT = 2
- Sub-module datamem_byte_ram: word array with four per-lane write enables and a combinational read of the captured word address. The responder holds the FSM, the capture registers and the legality check.

Test Plan:
- Reset, then store addr 0x010, be=1111, data 0xDEADBEEF; then load addr 0x010 -> resp_valid exactly 3 cycles after each accept (WAIT_STATES=2), resp_read_data=0xDEADBEEF, resp_error=0.
- Store addr 0x012, be=1100, data 0x12340000 over the above; load 0x010 -> 0x1234BEEF. Store be=0010, data 0x00005600; load -> 0x123456EF.
- Store be=0101 or be=0000 to 0x020 holding 0xCAFEF00D -> resp_error=1, resp_read_data=0; a following load still returns 0xCAFEF00D.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, data and error stay constant, req_ready=0 throughout; the response completes on the first cycle with resp_ready=1.
- Assert reset in the second WAIT cycle of a store to 0x030 (old 0x11111111) -> FSM returns to IDLE, outputs are zero, a later load returns 0x11111111.
- WAIT_STATES=0 build: accept at T -> resp_valid at T+1. With DATAMEM_ACCESS_STATS_EN, 3 loads, 2 stores and 1 error give load_count=3, store_count=2.
